// File: rtl/mpu_matrix_mem.sv
// Matrix slot memory serving mpu_load (row-major element stream with ack) and capturing mpu_store beats.
// Optional MPU_MEM_STATS_EN adds saturating completed-load / completed-store counters.
module mpu_matrix_mem #(
  parameter int FP    = 32,
  parameter int M     = 4,
  parameter int N     = 4,
  parameter int DEPTH = 8,
  localparam int MBITS = $clog2(M),
  localparam int NBITS = $clog2(N),
  localparam int AW    = $clog2(DEPTH),
  localparam int IW    = MBITS + NBITS,
  localparam int MW    = MBITS + 1,
  localparam int NW    = NBITS + 1,
  localparam int TW    = MBITS + NBITS + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          host_wr_en_in,
  input  logic [AW-1:0] host_addr_in,
  input  logic [IW-1:0] host_idx_in,
  input  logic [FP-1:0] host_data_in,
  input  logic [MW-1:0] host_m_in,
  input  logic [NW-1:0] host_n_in,
  input  logic          load_req_in,
  input  logic [AW-1:0] load_addr_in,
  input  logic          load_ack_in,
  input  logic          load_error_in,
  output logic          load_valid_out,
  output logic [FP-1:0] load_element_out,
  output logic [MW-1:0] load_m_size_out,
  output logic [NW-1:0] load_n_size_out,
  output logic          load_err_out,
  input  logic          store_en_in,
  input  logic [AW-1:0] store_addr_in,
  input  logic [FP-1:0] store_element_in,
  input  logic [MW-1:0] store_m_size_in,
  input  logic [NW-1:0] store_n_size_in,
  output logic          store_done_out,
  output logic          busy_out
`ifdef MPU_MEM_STATS_EN
  ,
  output logic [15:0]   load_count_out,
  output logic [15:0]   store_count_out
`endif
);

  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_LOAD = 2'd1, ST_STORE = 2'd2} state_e;

  state_e        state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [MW-1:0] m_q, m_d;
  logic [NW-1:0] n_q, n_d;
  logic [TW-1:0] total_q, total_d;
  logic          load_valid_q, load_valid_d;
  logic          load_err_q, load_err_d;
  logic          store_done_q, store_done_d;
  logic          load_done_s;

  logic [FP-1:0] mem_q [DEPTH][M*N];
  logic [MW-1:0] slot_m_q [DEPTH];
  logic [NW-1:0] slot_n_q [DEPTH];

  logic          mem_we_s;
  logic [AW-1:0] mem_waddr_s;
  logic [IW-1:0] mem_widx_s;
  logic [FP-1:0] mem_wdata_s;
  logic          sz_we_s;
  logic [AW-1:0] sz_waddr_s;
  logic [MW-1:0] sz_m_s;
  logic [NW-1:0] sz_n_s;

  function automatic logic size_ok(input logic [MW-1:0] m, input logic [NW-1:0] n);
    size_ok = (m != '0) && (m <= MW'(M)) && (n != '0) && (n <= NW'(N));
  endfunction

  function automatic logic [TW-1:0] size_total(input logic [MW-1:0] m, input logic [NW-1:0] n);
    size_total = TW'(m) * TW'(n);
  endfunction

  // Next-state, datapath and memory write-port selection
  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    idx_d        = idx_q;
    m_d          = m_q;
    n_d          = n_q;
    total_d      = total_q;
    load_valid_d = load_valid_q;
    load_err_d   = 1'b0;
    store_done_d = 1'b0;
    load_done_s  = 1'b0;
    mem_we_s     = 1'b0;
    mem_waddr_s  = '0;
    mem_widx_s   = '0;
    mem_wdata_s  = '0;
    sz_we_s      = 1'b0;
    sz_waddr_s   = '0;
    sz_m_s       = '0;
    sz_n_s       = '0;
    case (state_q)
      ST_IDLE: begin
        if (store_en_in) begin
          if (size_ok(store_m_size_in, store_n_size_in)) begin
            mem_we_s    = 1'b1;
            mem_waddr_s = store_addr_in;
            mem_widx_s  = '0;
            mem_wdata_s = store_element_in;
            if (size_total(store_m_size_in, store_n_size_in) == TW'(1)) begin
              store_done_d = 1'b1;
              sz_we_s      = 1'b1;
              sz_waddr_s   = store_addr_in;
              sz_m_s       = store_m_size_in;
              sz_n_s       = store_n_size_in;
            end else begin
              state_d = ST_STORE;
              addr_d  = store_addr_in;
              m_d     = store_m_size_in;
              n_d     = store_n_size_in;
              total_d = size_total(store_m_size_in, store_n_size_in);
              idx_d   = IW'(1);
            end
          end else begin
            state_d = ST_IDLE;
          end
        end else if (load_req_in) begin
          if (size_ok(slot_m_q[load_addr_in], slot_n_q[load_addr_in])) begin
            state_d      = ST_LOAD;
            addr_d       = load_addr_in;
            idx_d        = '0;
            m_d          = slot_m_q[load_addr_in];
            n_d          = slot_n_q[load_addr_in];
            total_d      = size_total(slot_m_q[load_addr_in], slot_n_q[load_addr_in]);
            load_valid_d = 1'b1;
          end else begin
            load_err_d = 1'b1;
          end
        end else if (host_wr_en_in) begin
          mem_we_s    = 1'b1;
          mem_waddr_s = host_addr_in;
          mem_widx_s  = host_idx_in;
          mem_wdata_s = host_data_in;
          sz_we_s     = 1'b1;
          sz_waddr_s  = host_addr_in;
          sz_m_s      = host_m_in;
          sz_n_s      = host_n_in;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_LOAD: begin
        if (load_error_in) begin
          load_valid_d = 1'b0;
          load_err_d   = 1'b1;
          idx_d        = '0;
          state_d      = ST_IDLE;
        end else if (load_valid_q && load_ack_in) begin
          if ({1'b0, idx_q} == total_q - TW'(1)) begin
            load_valid_d = 1'b0;
            load_done_s  = 1'b1;
            idx_d        = '0;
            state_d      = ST_IDLE;
          end else begin
            idx_d = idx_q + IW'(1);
          end
        end else begin
          idx_d = idx_q;
        end
      end
      ST_STORE: begin
        if (store_en_in) begin
          mem_we_s    = 1'b1;
          mem_waddr_s = addr_q;
          mem_widx_s  = idx_q;
          mem_wdata_s = store_element_in;
          if ({1'b0, idx_q} == total_q - TW'(1)) begin
            // Slot size becomes visible only once the whole matrix is in place
            store_done_d = 1'b1;
            sz_we_s      = 1'b1;
            sz_waddr_s   = addr_q;
            sz_m_s       = m_q;
            sz_n_s       = n_q;
            idx_d        = '0;
            state_d      = ST_IDLE;
          end else begin
            idx_d = idx_q + IW'(1);
          end
        end else begin
          idx_d = idx_q;
        end
      end
      default: begin
        state_d      = ST_IDLE;
        load_valid_d = 1'b0;
      end
    endcase
  end

  // Control and handshake registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      addr_q       <= '0;
      idx_q        <= '0;
      m_q          <= '0;
      n_q          <= '0;
      total_q      <= '0;
      load_valid_q <= 1'b0;
      load_err_q   <= 1'b0;
      store_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      idx_q        <= idx_d;
      m_q          <= m_d;
      n_q          <= n_d;
      total_q      <= total_d;
      load_valid_q <= load_valid_d;
      load_err_q   <= load_err_d;
      store_done_q <= store_done_d;
    end
  end

  // Per-slot size table; zero marks a slot as never written
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        slot_m_q[i] <= '0;
        slot_n_q[i] <= '0;
      end
    end else if (sz_we_s) begin
      slot_m_q[sz_waddr_s] <= sz_m_s;
      slot_n_q[sz_waddr_s] <= sz_n_s;
    end
  end

  // Element storage, no reset
  always_ff @(posedge clk) begin
    if (mem_we_s) begin
      mem_q[mem_waddr_s][mem_widx_s] <= mem_wdata_s;
    end
  end

`ifdef MPU_MEM_STATS_EN
  logic [15:0] load_count_q, store_count_q;

  // Saturating completion counters
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      load_count_q  <= 16'h0000;
      store_count_q <= 16'h0000;
    end else begin
      if (load_done_s && (load_count_q != 16'hFFFF)) begin
        load_count_q <= load_count_q + 16'h0001;
      end
      if (store_done_d && (store_count_q != 16'hFFFF)) begin
        store_count_q <= store_count_q + 16'h0001;
      end
    end
  end

  assign load_count_out  = load_count_q;
  assign store_count_out = store_count_q;
`endif

  assign load_valid_out   = load_valid_q;
  assign load_element_out = load_valid_q ? mem_q[addr_q][idx_q] : '0;
  assign load_m_size_out  = load_valid_q ? m_q : '0;
  assign load_n_size_out  = load_valid_q ? n_q : '0;
  assign load_err_out     = load_err_q;
  assign store_done_out   = store_done_q;
  assign busy_out         = (state_q != ST_IDLE);

endmodule

// File: tb/tb_mpu_matrix_mem.sv
// Self-checking bench for mpu_matrix_mem: directed scenarios plus randomized store/reload
// checked against a slot-array reference model.
module tb_mpu_matrix_mem;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        host_wr_en_in = 1'b0;
  logic [2:0]  host_addr_in = 3'd0;
  logic [3:0]  host_idx_in = 4'd0;
  logic [31:0] host_data_in = 32'd0;
  logic [2:0]  host_m_in = 3'd0;
  logic [2:0]  host_n_in = 3'd0;
  logic        load_req_in = 1'b0;
  logic [2:0]  load_addr_in = 3'd0;
  logic        load_ack_in = 1'b0;
  logic        load_error_in = 1'b0;
  logic        load_valid_out;
  logic [31:0] load_element_out;
  logic [2:0]  load_m_size_out;
  logic [2:0]  load_n_size_out;
  logic        load_err_out;
  logic        store_en_in = 1'b0;
  logic [2:0]  store_addr_in = 3'd0;
  logic [31:0] store_element_in = 32'd0;
  logic [2:0]  store_m_size_in = 3'd0;
  logic [2:0]  store_n_size_in = 3'd0;
  logic        store_done_out;
  logic        busy_out;

  mpu_matrix_mem dut (
    .clk(clk), .rst(rst),
    .host_wr_en_in(host_wr_en_in), .host_addr_in(host_addr_in), .host_idx_in(host_idx_in),
    .host_data_in(host_data_in), .host_m_in(host_m_in), .host_n_in(host_n_in),
    .load_req_in(load_req_in), .load_addr_in(load_addr_in), .load_ack_in(load_ack_in),
    .load_error_in(load_error_in), .load_valid_out(load_valid_out),
    .load_element_out(load_element_out), .load_m_size_out(load_m_size_out),
    .load_n_size_out(load_n_size_out), .load_err_out(load_err_out),
    .store_en_in(store_en_in), .store_addr_in(store_addr_in),
    .store_element_in(store_element_in), .store_m_size_in(store_m_size_in),
    .store_n_size_in(store_n_size_in), .store_done_out(store_done_out), .busy_out(busy_out)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  // Reference model: slot contents and sizes
  logic [31:0] mdl_mem [8][16];
  int          mdl_m [8];
  int          mdl_n [8];

  // Results gathered by the drivers
  logic [31:0] got_q[$];
  logic [31:0] st_data_q[$];
  int got_m, got_n, err_cycles, hold_bad, busy_after;
  bit saw_valid, timed_out;
  int done_early, done_seen;

  task automatic host_write(input int a, input int idx, input logic [31:0] d, input int m, input int n);
    @(negedge clk);
    host_wr_en_in = 1'b1; host_addr_in = 3'(a); host_idx_in = 4'(idx);
    host_data_in = d; host_m_in = 3'(m); host_n_in = 3'(n);
    @(negedge clk);
    host_wr_en_in = 1'b0;
    mdl_mem[a][idx] = d; mdl_m[a] = m; mdl_n[a] = n;
  endtask

  // mode 0: ack every valid cycle; 1: ack alternate cycles; 2: raise load_error_in after two acks
  task automatic collect_load(input int a, input int mode);
    logic [31:0] prev_e;
    bit prev_v, prev_a, ack, fin;
    int nval;
    got_q.delete();
    got_m = 0; got_n = 0; err_cycles = 0; hold_bad = 0; saw_valid = 1'b0; timed_out = 1'b0;
    prev_e = 32'd0; prev_v = 1'b0; prev_a = 1'b0; nval = 0; fin = 1'b0;
    @(negedge clk);
    load_req_in = 1'b1; load_addr_in = 3'(a);
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      load_req_in = 1'b0; load_ack_in = 1'b0; load_error_in = 1'b0;
      if (load_err_out) err_cycles++;
      if (load_valid_out) begin
        if (!saw_valid) begin got_m = int'(load_m_size_out); got_n = int'(load_n_size_out); end
        saw_valid = 1'b1;
        if (prev_v && !prev_a && load_element_out !== prev_e) hold_bad++;
        prev_e = load_element_out; prev_v = 1'b1;
        ack = 1'b1;
        if (mode == 1) ack = nval[0];
        if (mode == 2 && got_q.size() == 2) begin ack = 1'b0; load_error_in = 1'b1; end
        load_ack_in = ack;
        if (ack) got_q.push_back(load_element_out);
        prev_a = ack;
        nval++;
      end else if (saw_valid || err_cycles > 0) begin
        fin = 1'b1;
        break;
      end else begin
        prev_v = 1'b0;
      end
    end
    if (!fin) timed_out = 1'b1;
    load_ack_in = 1'b0; load_error_in = 1'b0;
    @(negedge clk);
    if (load_err_out) err_cycles++;
    if (load_valid_out) hold_bad++;
    busy_after = int'(busy_out);
  endtask

  // Drives st_data_q as a burst; gap_at inserts one idle cycle before that beat
  task automatic drive_store(input int a, input int m, input int n, input int gap_at, input int nbeats);
    done_early = 0; done_seen = 0;
    for (int b = 0; b < nbeats; b++) begin
      if (b == gap_at) begin
        @(negedge clk);
        if (store_done_out) done_early++;
        store_en_in = 1'b0;
      end
      @(negedge clk);
      if (store_done_out) done_early++;
      store_en_in = 1'b1;
      store_element_in = st_data_q[b];
      store_addr_in = (b == 0) ? 3'(a) : 3'($urandom);
      store_m_size_in = (b == 0) ? 3'(m) : 3'($urandom);
      store_n_size_in = (b == 0) ? 3'(n) : 3'($urandom);
    end
    @(negedge clk);
    store_en_in = 1'b0;
    done_seen = int'(store_done_out);
    busy_after = int'(busy_out);
    @(negedge clk);
    if (store_done_out) done_early++;
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    total++; if (load_valid_out !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", load_valid_out); end
    total++; if (load_err_out !== 1'b0) begin bad++; $display("FAIL reset_err got=%b exp=0", load_err_out); end
    total++; if (store_done_out !== 1'b0) begin bad++; $display("FAIL reset_done got=%b exp=0", store_done_out); end
    total++; if (busy_out !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy_out); end
    total++; if (load_element_out !== 32'd0) begin bad++; $display("FAIL reset_elem got=%h exp=0", load_element_out); end
    rst = 1'b1;
    for (int s = 0; s < 8; s++) begin mdl_m[s] = 0; mdl_n[s] = 0; end
  endtask

  task automatic check_stream(input string name, input int a, input int exp_len);
    total++;
    if (timed_out) begin bad++; $display("FAIL %s_timeout got=1 exp=0", name); end
    total++;
    if (got_q.size() != exp_len) begin bad++; $display("FAIL %s_len got=%0d exp=%0d", name, got_q.size(), exp_len); end
    for (int k = 0; k < got_q.size() && k < exp_len; k++) begin
      total++;
      if (got_q[k] !== mdl_mem[a][k]) begin bad++; $display("FAIL %s_elem%0d got=%h exp=%h", name, k, got_q[k], mdl_mem[a][k]); end
    end
  endtask

  task automatic test_load_full_ack;
    logic [31:0] init [4];
    init[0] = 32'h3f800000; init[1] = 32'h424951ec; init[2] = 32'hc0200000; init[3] = 32'h3e000000;
    for (int k = 0; k < 4; k++) host_write(0, k, init[k], 2, 2);
    collect_load(0, 0);
    check_stream("load_full", 0, 4);
    total++; if (got_m != 2 || got_n != 2) begin bad++; $display("FAIL load_full_size got=%0dx%0d exp=2x2", got_m, got_n); end
    total++; if (busy_after != 0) begin bad++; $display("FAIL load_full_busy got=%0d exp=0", busy_after); end
    total++; if (err_cycles != 0 || hold_bad != 0) begin bad++; $display("FAIL load_full_clean got err=%0d hold=%0d exp=0", err_cycles, hold_bad); end
  endtask

  task automatic test_load_alt_ack;
    collect_load(0, 1);
    check_stream("load_alt", 0, 4);
    total++; if (hold_bad != 0) begin bad++; $display("FAIL load_alt_hold got=%0d exp=0", hold_bad); end
  endtask

  task automatic test_load_bad_slot;
    collect_load(3, 0);
    total++; if (err_cycles != 1) begin bad++; $display("FAIL bad_slot_err got=%0d exp=1", err_cycles); end
    total++; if (saw_valid) begin bad++; $display("FAIL bad_slot_valid got=1 exp=0"); end
    total++; if (busy_after != 0) begin bad++; $display("FAIL bad_slot_busy got=%0d exp=0", busy_after); end
  endtask

  task automatic test_store_gap;
    st_data_q.delete();
    for (int k = 0; k < 6; k++) begin st_data_q.push_back($urandom); mdl_mem[1][k] = st_data_q[k]; end
    drive_store(1, 2, 3, 3, 6);
    mdl_m[1] = 2; mdl_n[1] = 3;
    total++; if (done_seen != 1 || done_early != 0) begin bad++; $display("FAIL store_gap_done got=%0d early=%0d exp=1/0", done_seen, done_early); end
    total++; if (busy_after != 0) begin bad++; $display("FAIL store_gap_busy got=%0d exp=0", busy_after); end
    collect_load(1, 0);
    check_stream("store_reload", 1, 6);
    total++; if (got_m != 2 || got_n != 3) begin bad++; $display("FAIL store_reload_size got=%0dx%0d exp=2x3", got_m, got_n); end
  endtask

  task automatic test_abort;
    collect_load(1, 2);
    check_stream("abort", 1, 2);
    total++; if (err_cycles != 1) begin bad++; $display("FAIL abort_err got=%0d exp=1", err_cycles); end
    total++; if (busy_after != 0 || hold_bad != 0) begin bad++; $display("FAIL abort_idle got busy=%0d valid_late=%0d exp=0", busy_after, hold_bad); end
  endtask

  task automatic test_priority;
    logic [31:0] d;
    d = $urandom;
    @(negedge clk);
    store_en_in = 1'b1; store_addr_in = 3'd2; store_m_size_in = 3'd1; store_n_size_in = 3'd1;
    store_element_in = d; load_req_in = 1'b1; load_addr_in = 3'd0;
    @(negedge clk);
    store_en_in = 1'b0; load_req_in = 1'b0;
    mdl_mem[2][0] = d; mdl_m[2] = 1; mdl_n[2] = 1;
    total++; if (store_done_out !== 1'b1) begin bad++; $display("FAIL prio_done got=%b exp=1", store_done_out); end
    total++; if (load_valid_out !== 1'b0) begin bad++; $display("FAIL prio_load got=%b exp=0", load_valid_out); end
    collect_load(2, 0);
    check_stream("prio_reload", 2, 1);
  endtask

  task automatic test_random;
    int a, m, n, len, gap;
    for (int it = 0; it < 8; it++) begin
      a = $urandom_range(0, 7); m = $urandom_range(1, 4); n = $urandom_range(1, 4);
      len = m * n;
      gap = (len > 1) ? $urandom_range(1, len) : -1;
      st_data_q.delete();
      for (int k = 0; k < len; k++) begin st_data_q.push_back($urandom); mdl_mem[a][k] = st_data_q[k]; end
      drive_store(a, m, n, gap, len);
      mdl_m[a] = m; mdl_n[a] = n;
      total++; if (done_seen != 1 || done_early != 0) begin bad++; $display("FAIL rand_done%0d got=%0d early=%0d exp=1/0", it, done_seen, done_early); end
      a = $urandom_range(0, 7);
      collect_load(a, $urandom_range(0, 1));
      if (mdl_m[a] == 0) begin
        total++; if (err_cycles != 1 || saw_valid) begin bad++; $display("FAIL rand_empty%0d got err=%0d valid=%0d exp=1/0", it, err_cycles, saw_valid); end
      end else begin
        check_stream("rand", a, mdl_m[a] * mdl_n[a]);
        total++; if (got_m != mdl_m[a] || got_n != mdl_n[a]) begin bad++; $display("FAIL rand_size%0d got=%0dx%0d exp=%0dx%0d", it, got_m, got_n, mdl_m[a], mdl_n[a]); end
      end
    end
  endtask

  task automatic test_rst_mid_store;
    st_data_q.delete();
    for (int k = 0; k < 4; k++) st_data_q.push_back($urandom);
    drive_store(1, 2, 2, -1, 2);
    total++; if (busy_out !== 1'b1) begin bad++; $display("FAIL rst_store_busy_before got=%b exp=1", busy_out); end
    #2 rst = 1'b0;
    #1;
    total++; if (busy_out !== 1'b0 || store_done_out !== 1'b0 || load_valid_out !== 1'b0) begin
      bad++; $display("FAIL rst_store_outputs got busy=%b done=%b valid=%b exp=0", busy_out, store_done_out, load_valid_out);
    end
    for (int s = 0; s < 8; s++) begin mdl_m[s] = 0; mdl_n[s] = 0; end
    @(negedge clk);
    rst = 1'b1;
    collect_load(1, 0);
    total++; if (err_cycles != 1 || saw_valid) begin bad++; $display("FAIL rst_store_size got err=%0d valid=%0d exp=1/0", err_cycles, saw_valid); end
    collect_load(0, 0);
    total++; if (err_cycles != 1 || saw_valid) begin bad++; $display("FAIL rst_slot0_size got err=%0d valid=%0d exp=1/0", err_cycles, saw_valid); end
  endtask

  initial begin
    test_reset();
    test_load_full_ack();
    test_load_alt_ack();
    test_load_bad_slot();
    test_store_gap();
    test_abort();
    test_priority();
    test_random();
    test_rst_mid_store();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
